mag_block_average: RTL and testbench

MAG_BLOCK_AVERAGE -- requirements
Module: mag_block_average

---
 rtl/mag_block_average.sv | 103 ++++++++++
 tb/tb_mag_block_average.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mag_block_average.sv
// Block averager for unsigned magnitudes: sums 2^blockShift valid samples and emits the
// sum normalized to a fixed scale. Optional block peak output with MAG_BLOCK_AVERAGE_PEAK_EN.
module mag_block_average #(
    parameter int DATA_WIDTH  = 23,
    parameter int SHIFT_WIDTH = 3
) (
    input  logic                                           clk,
    input  logic                                           reset,
    input  logic [SHIFT_WIDTH-1:0]                         blockShift,
    input  logic                                           restart,
    input  logic                                           S_TVALID,
    input  logic [DATA_WIDTH-1:0]                          S_TDATA,
    output logic                                           M_TVALID,
`ifdef MAG_BLOCK_AVERAGE_PEAK_EN
    output logic [DATA_WIDTH-1:0]                          M_TPEAK,
`endif
    output logic [DATA_WIDTH+((1<<SHIFT_WIDTH)-1)-1:0]     M_TDATA
);

    localparam int MAXSHIFT = (1 << SHIFT_WIDTH) - 1;
    localparam int ACC_W    = DATA_WIDTH + MAXSHIFT;
    localparam int CNT_W    = MAXSHIFT + 1;
    localparam logic [SHIFT_WIDTH-1:0] MAXSHIFT_S = SHIFT_WIDTH'(MAXSHIFT);

    logic [ACC_W-1:0]       r_acc;
    logic [CNT_W-1:0]       r_count;
    logic [SHIFT_WIDTH-1:0] r_shift;
    logic [ACC_W-1:0]       r_data;
    logic                   r_vld;

    logic                   w_restart;
    logic [CNT_W-1:0]       w_count_next;
    logic [CNT_W-1:0]       w_target;
    logic                   w_last;
    logic [ACC_W-1:0]       w_sum;
    logic [SHIFT_WIDTH-1:0] w_oshift;

    // A changed block length invalidates the partial sum just like an explicit restart.
    assign w_restart    = restart | (blockShift != r_shift);
    assign w_count_next = r_count + CNT_W'(1);
    assign w_target     = CNT_W'(1) << r_shift;
    assign w_last       = (w_count_next == w_target);
    assign w_sum        = r_acc + ACC_W'(S_TDATA);
    assign w_oshift     = MAXSHIFT_S - r_shift;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc   <= '0;
            r_count <= '0;
            r_shift <= '0;
            r_data  <= '0;
            r_vld   <= 1'b0;
        end else begin
            r_vld <= 1'b0;
            if (w_restart) begin
                r_shift <= blockShift;
                r_acc   <= '0;
                r_count <= '0;
            end else if (S_TVALID) begin
                if (w_last) begin
                    // Normalize so every block length lands on the same output scale.
                    r_data  <= w_sum << w_oshift;
                    r_vld   <= 1'b1;
                    r_acc   <= '0;
                    r_count <= '0;
                end else begin
                    r_acc   <= w_sum;
                    r_count <= w_count_next;
                end
            end
        end
    end

    assign M_TVALID = r_vld;
    assign M_TDATA  = r_data;

`ifdef MAG_BLOCK_AVERAGE_PEAK_EN
    logic [DATA_WIDTH-1:0] r_peak;
    logic [DATA_WIDTH-1:0] r_peak_out;
    logic [DATA_WIDTH-1:0] w_peak_max;

    assign w_peak_max = (S_TDATA > r_peak) ? S_TDATA : r_peak;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_peak     <= '0;
            r_peak_out <= '0;
        end else if (w_restart) begin
            r_peak <= '0;
        end else if (S_TVALID) begin
            if (w_last) begin
                r_peak_out <= w_peak_max;
                r_peak     <= '0;
            end else begin
                r_peak <= w_peak_max;
            end
        end
    end

    assign M_TPEAK = r_peak_out;
`endif

endmodule

// File: tb/tb_mag_block_average.sv
// Directed bench for mag_block_average: a spec-level model queues expected block outputs,
// a negedge monitor pops and compares them on every M_TVALID pulse.
module tb_mag_block_average;

    localparam int DW  = 23;
    localparam int SW  = 3;
    localparam int MS  = 7;
    localparam int OW  = DW + MS;

    logic          clk = 1'b0;
    logic          reset;
    logic [SW-1:0] blockShift;
    logic          restart;
    logic          S_TVALID;
    logic [DW-1:0] S_TDATA;
    logic          M_TVALID;
    logic [OW-1:0] M_TDATA;
`ifdef MAG_BLOCK_AVERAGE_PEAK_EN
    logic [DW-1:0] M_TPEAK;
`endif

    mag_block_average #(.DATA_WIDTH(DW), .SHIFT_WIDTH(SW)) dut (
        .clk        (clk),
        .reset      (reset),
        .blockShift (blockShift),
        .restart    (restart),
        .S_TVALID   (S_TVALID),
        .S_TDATA    (S_TDATA),
        .M_TVALID   (M_TVALID),
`ifdef MAG_BLOCK_AVERAGE_PEAK_EN
        .M_TPEAK    (M_TPEAK),
`endif
        .M_TDATA    (M_TDATA)
    );

    always #5 clk = ~clk;

    int            checks = 0;
    int            errors = 0;
    int            pulses = 0;
    logic [OW-1:0] last_data = '0;
    logic [DW-1:0] last_peak = '0;
    logic [OW-1:0] exp_q[$];

    // Reference model state
    logic [SW-1:0] cur_bs = '0;
    logic [SW-1:0] m_shift = '0;
    longint        m_acc = 0;
    int            m_cnt = 0;

    always @(negedge clk) begin
        if (M_TVALID) begin
            logic [OW-1:0] exp_v;
            pulses++;
            last_data = M_TDATA;
`ifdef MAG_BLOCK_AVERAGE_PEAK_EN
            last_peak = M_TPEAK;
`endif
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL pulse_unexpected observed M_TDATA=%0d expected no pulse", M_TDATA);
            end
            if (exp_q.size() != 0) begin
                exp_v = exp_q.pop_front();
                checks++;
                assert (M_TDATA === exp_v) else begin
                    errors++;
                    $error("FAIL block_data observed=%0d expected=%0d", M_TDATA, exp_v);
                end
            end
        end
    end

    task automatic check(input string tag, input longint obs, input longint exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    // Drive one cycle of stimulus and advance the model; returns just after the capturing edge.
    task automatic drive(input logic v, input logic [DW-1:0] d, input logic rs);
        blockShift = cur_bs;
        restart    = rs;
        S_TVALID   = v;
        S_TDATA    = v ? d : DW'($urandom);
        if (rs || cur_bs != m_shift) begin
            m_shift = cur_bs;
            m_acc   = 0;
            m_cnt   = 0;
        end else if (v) begin
            m_acc += longint'(d);
            m_cnt++;
            if (m_cnt == (1 << m_shift)) begin
                exp_q.push_back(OW'(m_acc << (MS - m_shift)));
                m_acc = 0;
                m_cnt = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0);
    endtask

    initial begin
        int p0;
        int sent;
        reset      = 1'b1;
        blockShift = '0;
        restart    = 1'b0;
        S_TVALID   = 1'b0;
        S_TDATA    = '0;
        #1;
        check("reset_tvalid", M_TVALID, 0);
        check("reset_tdata", M_TDATA, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Shift 0: every sample passes through, scaled by 2^7
        cur_bs = 3'd0;
        p0 = pulses;
        drive(1'b1, 23'd5, 1'b0);
        check("s0_latency_vld", M_TVALID, 1);
        check("s0_data_5", M_TDATA, 640);
        drive(1'b1, 23'd0, 1'b0);
        check("s0_data_0", M_TDATA, 0);
        idle(2);
        check("s0_pulses", pulses - p0, 2);

        // Shift 2: 10,20,30,40 back-to-back
        cur_bs = 3'd2;
        idle(1);
        p0 = pulses;
        drive(1'b1, 23'd10, 1'b0);
        drive(1'b1, 23'd20, 1'b0);
        drive(1'b1, 23'd30, 1'b0);
        check("s2_no_early_vld", M_TVALID, 0);
        drive(1'b1, 23'd40, 1'b0);
        check("s2_vld_after_last", M_TVALID, 1);
        drive(1'b0, '0, 1'b0);
        check("s2_vld_one_cycle", M_TVALID, 0);
        check("s2_data_held", M_TDATA, 3200);
        idle(1);
        check("s2_pulses", pulses - p0, 1);
        check("s2_last_data", last_data, 3200);

        // Block length change mid-block discards partial sum and the changing sample
        p0 = pulses;
        drive(1'b1, 23'd1, 1'b0);
        drive(1'b1, 23'd2, 1'b0);
        drive(1'b1, 23'd3, 1'b0);
        cur_bs = 3'd1;
        drive(1'b1, 23'd4, 1'b0);
        check("chg_no_vld", M_TVALID, 0);
        drive(1'b1, 23'd6, 1'b0);
        drive(1'b1, 23'd8, 1'b0);
        idle(1);
        check("chg_pulses", pulses - p0, 1);
        check("chg_last_data", last_data, 896);

        // Restart on the 4th sample beats block completion
        cur_bs = 3'd2;
        idle(1);
        p0 = pulses;
        drive(1'b1, 23'd1, 1'b0);
        drive(1'b1, 23'd1, 1'b0);
        drive(1'b1, 23'd1, 1'b0);
        drive(1'b1, 23'd1, 1'b1);
        check("rst4_no_vld", M_TVALID, 0);
        idle(2);
        check("rst4_pulses", pulses - p0, 0);
        drive(1'b1, 23'd1, 1'b0);
        drive(1'b1, 23'd2, 1'b0);
        drive(1'b1, 23'd3, 1'b0);
        drive(1'b1, 23'd4, 1'b0);
        idle(1);
        check("rst4_recover_pulses", pulses - p0, 1);
        check("rst4_recover_data", last_data, 320);

        // Shift 7: 128 full-scale samples with random gaps carrying garbage data
        cur_bs = 3'd7;
        idle(1);
        p0 = pulses;
        sent = 0;
        while (sent < 128) begin
            if ($urandom_range(0, 2) == 0) drive(1'b0, '0, 1'b0);
            drive(1'b1, 23'h7FFFFF, 1'b0);
            sent++;
        end
        idle(2);
        check("s7_pulses", pulses - p0, 1);
        check("s7_full_scale", last_data, (64'd1 << 30) - 128);

        // Reset mid-block: outputs clear at once, partial block lost
        p0 = pulses;
        for (int i = 0; i < 5; i++) drive(1'b1, 23'd1000, 1'b0);
        reset = 1'b1;
        #1;
        check("midrst_tvalid", M_TVALID, 0);
        check("midrst_tdata", M_TDATA, 0);
        m_shift = '0;
        m_acc   = 0;
        m_cnt   = 0;
        S_TVALID = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 130; i++) drive(1'b1, 23'd1, 1'b0);
        idle(2);
        check("midrst_pulses", pulses - p0, 1);
        check("midrst_relaunch_data", last_data, 128);

`ifdef MAG_BLOCK_AVERAGE_PEAK_EN
        cur_bs = 3'd2;
        idle(1);
        drive(1'b1, 23'd7, 1'b0);
        drive(1'b1, 23'd99, 1'b0);
        drive(1'b1, 23'd3, 1'b0);
        drive(1'b1, 23'd12, 1'b0);
        check("peak_vld", M_TVALID, 1);
        check("peak_value", M_TPEAK, 99);
        idle(1);
        check("peak_data", last_data, 3872);
`endif

        check("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
